// File: rtl/sync_gate_pkg.sv
// Shared types for the sync/gate/done sequencer: state encoding and helpers.
// Imported by sgs_down_counter and sync_gate_seq.
package sync_gate_pkg;

  localparam int SGS_STATE_W = 3;

  typedef enum logic [SGS_STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_WAIT = 3'd2,
    S_GATE = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } sgs_state_e;

  function automatic logic sgs_is_busy(input sgs_state_e s);
    return (s != S_IDLE);
  endfunction

endpackage

// File: rtl/sgs_down_counter.sv
// Loadable down counter with a zero flag; holds at zero instead of wrapping.
// Used for the gate window and, when compiled in, the WAIT timeout.
module sgs_down_counter
  import sync_gate_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  // load wins over dec so a reload on the same cycle as a decrement is exact
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - ONE;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sync_gate_seq.sv
// Sync/Gate/Done sequencer: sync pulse, wait for enabled channels ready,
// gate window of latched length, done pulse. Optional WAIT timeout: SYNC_GATE_TIMEOUT_EN.
module sync_gate_seq
  import sync_gate_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NCH-1:0]         ch_en,
  input  logic [NCH-1:0]         ch_rdy,
  input  logic [CNT_W-1:0]       gate_len,
  output logic                   sync,
  output logic [NCH-1:0]         gate,
  output logic                   done,
  output logic                   err,
  output logic                   busy,
  output logic [SGS_STATE_W-1:0] state
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  if ((NCH < 1) || (NCH > 16)) begin : g_nch_range
    $error("sync_gate_seq: NCH must be within 1..16");
  end
  if (TIMEOUT >= (1 << CNT_W)) begin : g_timeout_range
    $error("sync_gate_seq: TIMEOUT must be below 2**CNT_W");
  end

  sgs_state_e       state_q, state_d;
  logic [NCH-1:0]   en_q;
  logic [CNT_W-1:0] len_q;
  logic             accept;
  logic             all_rdy;
  logic             gate_load;
  logic             gate_dec;
  logic             gate_zero;
  logic [CNT_W-1:0] gate_load_val;
  logic             to_hit;

  // Handshake: start is a level request with no ready back to the scheduler.
  // It is taken on the edge where state is IDLE, abort is low and ch_en is
  // nonzero; busy low means the next start will be considered.
  assign accept  = (state_q == S_IDLE) && start && !abort && (ch_en != '0);
  assign all_rdy = ((ch_rdy & en_q) == en_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q  <= '0;
      len_q <= '0;
    end else if (accept) begin
      en_q  <= ch_en;
      len_q <= (gate_len == '0) ? ONE : gate_len;
    end
  end

  // Counter is loaded with len_q-1 so GATE lasts exactly len_q cycles
  assign gate_load     = (state_q == S_WAIT) && all_rdy;
  assign gate_load_val = len_q - ONE;
  assign gate_dec      = (state_q == S_GATE);

  sgs_down_counter #(.CNT_W(CNT_W)) u_gate_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gate_load),
    .load_val (gate_load_val),
    .dec      (gate_dec),
    .zero     (gate_zero)
  );

`ifdef SYNC_GATE_TIMEOUT_EN
  // Loaded during SYNC so it reads TIMEOUT-1 in the first WAIT cycle and
  // reaches zero in the TIMEOUT-th WAIT cycle.
  localparam logic [CNT_W-1:0] TO_LOAD = (TIMEOUT > 1) ? CNT_W'(TIMEOUT - 1) : '0;

  logic to_load;
  logic to_dec;
  logic to_zero;

  assign to_load = (state_q == S_SYNC);
  assign to_dec  = (state_q == S_WAIT);

  sgs_down_counter #(.CNT_W(CNT_W)) u_to_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .load_val (TO_LOAD),
    .dec      (to_dec),
    .zero     (to_zero)
  );

  assign to_hit = to_zero;
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SYNC;
      end
      S_SYNC: state_d = S_WAIT;
      S_WAIT: begin
        // ready beats the timeout when both land in the same cycle
        if (all_rdy) begin
          state_d = S_GATE;
        end else if (to_hit) begin
          state_d = S_ERR;
        end
      end
      S_GATE: begin
        if (gate_zero) state_d = S_DONE;
      end
      S_DONE, S_ERR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  assign sync  = (state_q == S_SYNC);
  assign done  = (state_q == S_DONE);
  assign busy  = sgs_is_busy(state_q);
  assign gate  = (state_q == S_GATE) ? en_q : '0;
  assign state = state_q;

`ifdef SYNC_GATE_TIMEOUT_EN
  assign err = (state_q == S_ERR);
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_gate_seq.sv
// Bench for sync_gate_seq: table vectors, directed corner sequences and
// randomized transactions scored against a transaction-level model.
module tb_sync_gate_seq;

  localparam int NCH     = 4;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 20;
  localparam int W       = 11;

  localparam int ST_IDLE = 0;
  localparam int ST_SYNC = 1;
  localparam int ST_WAIT = 2;
  localparam int ST_GATE = 3;
  localparam int ST_DONE = 4;
  localparam int ST_ERR  = 5;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [NCH-1:0]   ch_en;
  logic [NCH-1:0]   ch_rdy;
  logic [CNT_W-1:0] gate_len;
  logic             sync;
  logic [NCH-1:0]   gate;
  logic             done;
  logic             err;
  logic             busy;
  logic [2:0]       state;

  sync_gate_seq #(.NCH(NCH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .ch_en    (ch_en),
    .ch_rdy   (ch_rdy),
    .gate_len (gate_len),
    .sync     (sync),
    .gate     (gate),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .state    (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  // ---------------- records / scoreboard ----------------
  typedef struct packed {
    logic       start;
    logic       abort;
    logic [3:0] ch_en;
    logic [3:0] ch_rdy;
    logic [7:0] gate_len;
  } stim_t;

  typedef struct {
    stim_t        s;
    logic [W-1:0] exp;
    string        tag;
  } vec_t;

  vec_t         vec[$];
  stim_t        stim_q[$];
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom);
  endfunction

  function automatic logic [7:0] rnd8();
    return 8'($urandom);
  endfunction

  function automatic stim_t mk_stim(input logic s, input logic a, input logic [3:0] e,
                                    input logic [3:0] r, input logic [7:0] l);
    stim_t x;
    x.start = s; x.abort = a; x.ch_en = e; x.ch_rdy = r; x.gate_len = l;
    return x;
  endfunction

  // Expected observable outputs for a phase of the sequence
  function automatic logic [W-1:0] exp_word(input int st, input logic [3:0] g);
    logic [W-1:0] w;
    w = '0;
    w[10:8] = st[2:0];
    w[7]    = (st == ST_SYNC);
    if (st == ST_GATE) w[6:3] = g;
    w[2]    = (st == ST_DONE);
    w[1]    = (st == ST_ERR);
    w[0]    = (st != ST_IDLE);
    return w;
  endfunction

  // Some enabled channel deliberately left not ready; others random
  function automatic logic [3:0] not_ready(input logic [3:0] en);
    logic [3:0] r;
    int k;
    r = rnd4() | en;
    do k = $urandom_range(0, 3); while (!en[k]);
    r[k] = 1'b0;
    return r;
  endfunction

  task automatic check(input logic [W-1:0] exp, input string tag);
    logic [W-1:0] act;
    act = {state, sync, gate, done, err, busy};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got state=%0d sync=%b gate=%b done=%b err=%b busy=%b, expected state=%0d sync=%b gate=%b done=%b err=%b busy=%b",
               tag, act[10:8], act[7], act[6:3], act[2], act[1], act[0],
               exp[10:8], exp[7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input stim_t s);
    start    = s.start;
    abort    = s.abort;
    ch_en    = s.ch_en;
    ch_rdy   = s.ch_rdy;
    gate_len = s.gate_len;
  endtask

  task automatic push(input stim_t s, input logic [W-1:0] e, input string t);
    stim_q.push_back(s);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  // Each cycle: check the outputs of this cycle, then apply this cycle's inputs
  task automatic run_queue();
    while (stim_q.size() > 0) begin
      @(negedge clk);
      check(exp_q.pop_front(), tag_q.pop_front());
      drive(stim_q.pop_front());
    end
  endtask

  task automatic add_row(input logic s, input logic a, input logic [3:0] e, input logic [3:0] r,
                         input logic [7:0] l, input int st, input logic [3:0] g, input string t);
    vec_t v;
    v.s   = mk_stim(s, a, e, r, l);
    v.exp = exp_word(st, g);
    v.tag = t;
    vec.push_back(v);
  endtask

  task automatic add_idle(input string t);
    int kind;
    kind = $urandom_range(0, 2);
    case (kind)
      0:       push(mk_stim(1'b0, 1'b0, rnd4(), rnd4(), rnd8()), exp_word(ST_IDLE, 4'b0), t);
      1:       push(mk_stim(1'b1, 1'b0, 4'b0, rnd4(), rnd8()), exp_word(ST_IDLE, 4'b0), t);
      default: push(mk_stim(1'b1, 1'b1, rnd4() | 4'b0001, rnd4(), rnd8()), exp_word(ST_IDLE, 4'b0), t);
    endcase
  endtask

  // Transaction model: start, one SYNC, d not-ready WAIT cycles plus the ready
  // one, max(len,1) GATE cycles, DONE, then IDLE. An abort on busy cycle
  // abort_at cuts the sequence short and the next cycle is IDLE.
  task automatic add_seq(input logic [3:0] en, input logic [7:0] len, input int d,
                         input int abort_at, input bit fixed, input logic [3:0] nr_val,
                         input logic [3:0] ok_val, input string t);
    int    gl, n, st;
    stim_t s;
    gl = (len == 8'd0) ? 1 : int'(len);
    n  = d + gl + 3;
    push(mk_stim(1'b1, 1'b0, en, fixed ? nr_val : rnd4(), len), exp_word(ST_IDLE, 4'b0), t);
    for (int i = 0; i < n; i++) begin
      if (i == 0)               st = ST_SYNC;
      else if (i <= d + 1)      st = ST_WAIT;
      else if (i <= d + 1 + gl) st = ST_GATE;
      else                      st = ST_DONE;
      s = mk_stim(rnd1(), (i == abort_at), rnd4(), fixed ? nr_val : rnd4(), rnd8());
      if (st == ST_WAIT) begin
        if (i <= d) s.ch_rdy = fixed ? nr_val : not_ready(en);
        else        s.ch_rdy = fixed ? ok_val : (rnd4() | en);
      end
      push(s, exp_word(st, en), t);
      if (i == abort_at) break;
    end
    push(mk_stim(1'b0, 1'b0, rnd4(), rnd4(), rnd8()), exp_word(ST_IDLE, 4'b0), t);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [3:0] en;
    logic [7:0] len;
    int         d, gl, n, ab;

    // vector table: basic sequence, ignored starts, gate_len 0
    add_row(1, 0, 4'b0101, 4'hF, 8'd3, ST_IDLE, 4'b0,    "t_basic_start");
    add_row(0, 0, 4'b0000, 4'hF, 8'd0, ST_SYNC, 4'b0,    "t_basic_sync");
    add_row(0, 0, 4'b0000, 4'hF, 8'd0, ST_WAIT, 4'b0,    "t_basic_wait");
    add_row(1, 0, 4'b1111, 4'h0, 8'd7, ST_GATE, 4'b0101, "t_basic_gate0");
    add_row(1, 0, 4'b1111, 4'h0, 8'd7, ST_GATE, 4'b0101, "t_basic_gate1");
    add_row(1, 0, 4'b1111, 4'h0, 8'd7, ST_GATE, 4'b0101, "t_basic_gate2");
    add_row(1, 0, 4'b1111, 4'h0, 8'd7, ST_DONE, 4'b0,    "t_basic_done");
    add_row(0, 0, 4'b0000, 4'h0, 8'd0, ST_IDLE, 4'b0,    "t_basic_idle");
    add_row(1, 0, 4'b0000, 4'hF, 8'd4, ST_IDLE, 4'b0,    "t_zero_en_a");
    add_row(1, 1, 4'b0011, 4'hF, 8'd2, ST_IDLE, 4'b0,    "t_zero_en_b");
    add_row(0, 0, 4'b0000, 4'hF, 8'd0, ST_IDLE, 4'b0,    "t_abort_idle");
    add_row(1, 0, 4'b1000, 4'b1000, 8'd0, ST_IDLE, 4'b0, "t_len0_start");
    add_row(0, 0, 4'b0000, 4'b1000, 8'd0, ST_IDLE, 4'b0, "t_len0_idle");
    add_row(0, 0, 4'b0000, 4'b1000, 8'd0, ST_IDLE, 4'b0, "t_len0_idle2");

    // fix the expectations of the len0 rows that follow its start
    vec[12].exp = exp_word(ST_SYNC, 4'b0);
    vec[13].exp = exp_word(ST_WAIT, 4'b0);
    add_row(0, 0, 4'b0000, 4'b0000, 8'd0, ST_GATE, 4'b1000, "t_len0_gate");
    add_row(0, 0, 4'b0000, 4'b0000, 8'd0, ST_DONE, 4'b0,    "t_len0_done");
    add_row(0, 0, 4'b0000, 4'b0000, 8'd0, ST_IDLE, 4'b0,    "t_len0_idle3");

    rst = 1'b1;
    drive(mk_stim(1'b0, 1'b0, 4'b0, 4'b0, 8'd0));
    repeat (3) @(negedge clk);
    check(exp_word(ST_IDLE, 4'b0), "reset_held");
    rst = 1'b0;

    for (int i = 0; i < vec.size(); i++) begin
      @(negedge clk);
      check(vec[i].exp, vec[i].tag);
      drive(vec[i].s);
    end

    // ready arrives late: channel 0 ready for 10 WAIT cycles, then 0 and 2
    add_seq(4'b0101, 8'd2, 10, -1, 1'b1, 4'b0001, 4'b0101, "late_ready");
    run_queue();

    // abort in the second GATE cycle of a 5-cycle window
    add_seq(4'b0110, 8'd5, 0, 3, 1'b0, 4'b0, 4'b0, "abort_gate");
    run_queue();

    // ready on the last permitted WAIT cycle still proceeds to GATE
    add_seq(4'b1001, 8'd1, TIMEOUT - 1, -1, 1'b0, 4'b0, 4'b0, "ready_at_limit");
    run_queue();

    push(mk_stim(1'b1, 1'b0, 4'b1111, 4'b0, 8'd2), exp_word(ST_IDLE, 4'b0), "no_ready");
    push(mk_stim(1'b0, 1'b0, 4'b0, 4'b0, 8'd0), exp_word(ST_SYNC, 4'b0), "no_ready");
`ifdef SYNC_GATE_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT; i++)
      push(mk_stim(1'b0, 1'b0, 4'b0, 4'b0, 8'd0), exp_word(ST_WAIT, 4'b0), "timeout_wait");
    push(mk_stim(1'b0, 1'b0, 4'b0, 4'b0, 8'd0), exp_word(ST_ERR, 4'b0), "timeout_err");
    push(mk_stim(1'b0, 1'b0, 4'b0, 4'b0, 8'd0), exp_word(ST_IDLE, 4'b0), "timeout_idle");
`else
    for (int i = 0; i < 300; i++)
      push(mk_stim(1'b0, (i == 299), 4'b0, 4'b0, 8'd0), exp_word(ST_WAIT, 4'b0), "wait_forever");
    push(mk_stim(1'b0, 1'b0, 4'b0, 4'b0, 8'd0), exp_word(ST_IDLE, 4'b0), "wait_abort_idle");
`endif
    run_queue();

    // asynchronous reset in the middle of WAIT
    push(mk_stim(1'b1, 1'b0, 4'b0110, 4'b0, 8'd4), exp_word(ST_IDLE, 4'b0), "rst_pre");
    push(mk_stim(1'b0, 1'b0, 4'b0, 4'b0, 8'd0), exp_word(ST_SYNC, 4'b0), "rst_pre");
    push(mk_stim(1'b0, 1'b0, 4'b0, 4'b0, 8'd0), exp_word(ST_WAIT, 4'b0), "rst_pre");
    run_queue();
    @(posedge clk);
    #2;
    check(exp_word(ST_WAIT, 4'b0), "rst_before");
    rst = 1'b1;
    #1;
    check(exp_word(ST_IDLE, 4'b0), "rst_async");
    @(negedge clk);
    check(exp_word(ST_IDLE, 4'b0), "rst_held2");
    rst = 1'b0;
    add_seq(4'b0110, 8'd2, 1, -1, 1'b0, 4'b0, 4'b0, "after_rst");
    run_queue();

    // randomized transactions against the model
    for (int k = 0; k < 40; k++) begin
      en = rnd4();
      if (en == 4'b0) en[$urandom_range(0, 3)] = 1'b1;
      len = 8'($urandom_range(0, 6));
      d   = $urandom_range(0, 15);
      gl  = (len == 8'd0) ? 1 : int'(len);
      n   = d + gl + 3;
      ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      repeat ($urandom_range(0, 2)) add_idle("rand_idle");
      add_seq(en, len, d, ab, 1'b0, 4'b0, 4'b0, "rand_seq");
      run_queue();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
